fsm_grant_arbiter: RTL and testbench
====================================

# fsm_grant_arbiter

Round-robin arbiter with a sequencing state machine that shares one FSM-driven datapath resource between up to NUM_REQ requesters. It sits between requesting blocks and the shared resource. It issues one-hot, registered grants and enforces a one-cycle turnaround between owners. It can optionally pre-empt an owner that holds the resource too long.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..16.
- TIMEOUT, 16, maximum cycles an owner may hold the grant while others wait; legal range 2..255; used only with the timeout feature compiled in.

- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req  in  NUM_REQ  request vector. Bit i is held high by requester i for as long as it wants or holds the resource.
- grant  out  NUM_REQ  one-hot or zero, registered. Bit i means requester i owns the resource.
- busy  out  1  high whenever grant is non-zero.
- owner_id  out  $clog2(NUM_REQ)  index of the current or most recent owner.
- timeout_evt  out  1  one-cycle pulse when an owner is pre-empted.

## Operation
- States: IDLE, GRANT, TURN.
- IDLE:
  - grant is 0.
  - If req is non-zero, select the winner by round-robin search starting at ptr, ascending with wrap from NUM_REQ-1 to 0.
  - Register owner_id and grant[winner], then go to GRANT.
  - If req is 0, stay in IDLE.
- GRANT:
  - grant[owner_id] is 1.
  - Stay while req[owner_id] is 1. Changes on other req bits are ignored.
  - When req[owner_id] is 0, go to TURN.
- TURN:
  - grant is 0 for exactly one cycle.
  - ptr becomes (owner_id+1) mod NUM_REQ.
  - Then go to IDLE unconditionally.
- ptr is a round-robin pointer, reset to 0.
  - Result: requester 0 wins the first contention after reset.
  - A requester that just released has lowest priority in the next arbitration.
- busy is registered together with grant, so busy equals |grant.
- owner_id holds its value through TURN and IDLE until the next grant.
- Reset (async, any state): state=IDLE, grant=0, busy=0, owner_id=0, ptr=0, timeout_evt=0, hold counter=0. Reset mid-GRANT drops grant immediately, without waiting for a clock edge.

## Timing
- Request to grant:
  - req sampled high in IDLE at edge N makes grant high after edge N. Latency is 1 cycle.
  - From GRANT with other requesters pending, the minimum gap is 2 cycles: one TURN cycle, then one IDLE arbitration cycle.
- Release: req[owner] low sampled at edge N drops grant after edge N, so TURN is visible in cycle N+1.
- Back-to-back: the same requester re-requesting after its own release waits behind any other pending requester.
- A requester that drops req during IDLE before being granted is simply not selected.
- Simultaneous requests resolve in one cycle by round-robin order. There is no starvation: at most NUM_REQ-1 other grants occur before a pending requester is served.

## Configuration
- Macro FSM_GRANT_ARBITER_TIMEOUT_EN.
- Defined:
  - The hold counter increments each GRANT cycle and clears on entry to GRANT. It is 8 bits wide and saturates.
  - When the counter equals TIMEOUT-1 and any req bit other than owner_id is high, the block forces GRANT→TURN on the next edge and pulses timeout_evt for that same cycle (the first TURN cycle).
  - If the owner drops req in the same cycle the timeout fires, this is a normal release and timeout_evt stays 0.
  - If no other requester is waiting, the owner keeps the grant indefinitely.
- Not defined:
  - No counter logic.
  - timeout_evt is tied to 0.
  - An owner keeps the grant until it drops req.

## Test plan
- Single request: req=0001 for 5 cycles, then 0000. Expect grant=0001 from cycle 1 to cycle 5, 0 in the TURN cycle, busy matching, and owner_id=0 throughout.
- Contention after reset: req=1111 held. Expect grants in order 0001, 0010, 0100, 1000, 0001, with each owner dropping req after 3 cycles and a 2-cycle zero gap between grants.
- Fairness: owner 2 releases while req=0111. Expect the next grant to be 0001 (ptr=3 wraps to 0), not 0100.
- Timeout (macro on, TIMEOUT=4): req[1] held forever and req[3] asserted. Expect grant 0010 for 4 cycles, then timeout_evt=1 with grant=0, then grant=1000. With only req[1] asserted, expect no timeout.
- Reset mid-grant: assert rst_n=0 asynchronously while grant=0100. Expect grant=0, busy=0, owner_id=0 before the next clk edge. After release with req=0110, expect grant=0010.
- Macro off: the timeout scenario yields grant 0010 until req[1] drops, and timeout_evt stays 0.

Source files
------------

// File: rtl/fsm_grant_arbiter.sv
// rtl/fsm_grant_arbiter.sv - round-robin grant arbiter with one-cycle turnaround FSM
// Optional owner pre-emption: compile with FSM_GRANT_ARBITER_TIMEOUT_EN defined.
module fsm_grant_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] owner_id,
   output logic                       timeout_evt
);
   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               busy_q, busy_d;
   logic [IDW-1:0]     owner_q, owner_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [IDW-1:0]     winner;
   logic [IDW:0]       cand;
   logic               found;
   logic               owner_req;
   logic               preempt;

   // Elaboration guard on the supported parameter ranges
   if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
      $error("fsm_grant_arbiter: NUM_REQ or TIMEOUT out of range");
   end

   assign owner_req = req[owner_q];

`ifdef FSM_GRANT_ARBITER_TIMEOUT_EN
   logic [7:0] hold_q, hold_d;
   logic       evt_q, evt_d;
   logic       others_req;

   // Someone other than the current owner is asking for the resource
   assign others_req  = |(req & ~grant_q);
   assign preempt     = (hold_q == 8'(TIMEOUT - 1)) && others_req;
   assign timeout_evt = evt_q;

   // Hold counter clears while idle so it starts at zero on entry to GRANT
   always_comb begin
      hold_d = hold_q;
      evt_d  = 1'b0;
      if (state_q == IDLE) begin
         hold_d = '0;
      end else if (state_q == GRANT) begin
         if (hold_q != 8'hFF) hold_d = hold_q + 8'd1;
         // A simultaneous voluntary release is not reported as a pre-emption
         evt_d = owner_req && preempt;
      end
   end

   // Hold counter and pre-emption pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         evt_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         evt_q  <= evt_d;
      end
   end
`else
   assign preempt     = 1'b0;
   assign timeout_evt = 1'b0;
`endif

   // Round-robin search: first requester at or after ptr, wrapping at NUM_REQ-1
   always_comb begin
      winner = ptr_q;
      found  = 1'b0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
         if (!found && req[cand[IDW-1:0]]) begin
            winner = cand[IDW-1:0];
            found  = 1'b1;
         end
      end
   end

   // Next-state and registered-output logic for the grant sequencer
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               grant_d = NUM_REQ'(1) << winner;
               owner_d = winner;
            end
         end
         GRANT: begin
            if (!owner_req || preempt) begin
               state_d = TURN;
               grant_d = '0;
            end
         end
         TURN: begin
            // The releasing owner becomes lowest priority for the next arbitration
            state_d = IDLE;
            ptr_d   = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
      busy_d = |grant_d;
   end

   // State, grant, owner and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         busy_q  <= 1'b0;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant    = grant_q;
   assign busy     = busy_q;
   assign owner_id = owner_q;

endmodule

// File: tb/tb_fsm_grant_arbiter.sv
// tb/tb_fsm_grant_arbiter.sv - self-checking bench for fsm_grant_arbiter
module tb_fsm_grant_arbiter;
   localparam int N          = 4;
   localparam int IDW        = 2;
   localparam int TB_TIMEOUT = 4;
`ifdef FSM_GRANT_ARBITER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam logic [N-1:0] ONE = 1;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   grant;
   logic           busy;
   logic [IDW-1:0] owner_id;
   logic           timeout_evt;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns, whether a release gap is pending, rotation origin
   int m_owner;
   int m_last;
   int m_ptr;
   int m_hold;
   bit m_turn;
   bit m_evt;

   fsm_grant_arbiter #(.NUM_REQ(N), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .busy        (busy),
      .owner_id    (owner_id),
      .timeout_evt (timeout_evt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_owner = -1;
      m_last  = 0;
      m_ptr   = 0;
      m_hold  = 0;
      m_turn  = 1'b0;
      m_evt   = 1'b0;
   endtask

   task automatic model_edge();
      m_evt = 1'b0;
      if (m_owner >= 0) begin
         bit others;
         others = (req & ~(ONE << m_owner)) != '0;
         if (!req[m_owner] || (TO_EN && m_hold == TB_TIMEOUT - 1 && others)) begin
            m_evt   = req[m_owner];
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_turn  = 1'b1;
         end else if (m_hold < 255) begin
            m_hold++;
         end
      end else if (m_turn) begin
         m_turn = 1'b0;
      end else if (req != '0) begin
         for (int k = N - 1; k >= 0; k--)
            if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
         m_last = m_owner;
         m_hold = 0;
      end
   endtask

   function automatic logic [N+IDW+1:0] exp_vec();
      logic [N-1:0] g;
      g = (m_owner >= 0) ? (ONE << m_owner) : '0;
      return {g, |g, IDW'(m_last), m_evt};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({grant, busy, owner_id, timeout_evt} !== '0) begin
         errors++;
         $display("FAIL reset_async got %b exp 0", {grant, busy, owner_id, timeout_evt});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if ({grant, busy, owner_id, timeout_evt} !== exp_vec()) begin
         errors++;
         $display("FAIL reset_idle got %b exp %b", {grant, busy, owner_id, timeout_evt}, exp_vec());
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0001;
      for (int c = 1; c <= 5; c++) begin
         tick();
         checks++;
         if (grant !== 4'b0001 || busy !== 1'b1 || owner_id !== 2'd0 ||
             {grant, busy, owner_id, timeout_evt} !== exp_vec()) begin
            errors++;
            $display("FAIL single_hold cyc%0d got g=%b b=%b o=%0d exp g=0001 b=1 o=0", c, grant, busy, owner_id);
         end
      end
      req = 4'b0000;
      tick();
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0 || owner_id !== 2'd0 ||
          {grant, busy, owner_id, timeout_evt} !== exp_vec()) begin
         errors++;
         $display("FAIL single_turn got g=%b b=%b o=%0d exp g=0000 b=0 o=0", grant, busy, owner_id);
      end
   endtask

   task automatic test_contention();
      logic [N-1:0] seq[$];
      int           gaps[$];
      logic [N-1:0] exp_seq[5];
      int           held = 0;
      int           gap  = 0;
      int           cyc  = 0;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      req = 4'b1111;
      while (seq.size() < 5 && cyc < 100) begin
         tick();
         cyc++;
         checks++;
         if ({grant, busy, owner_id, timeout_evt} !== exp_vec()) begin
            errors++;
            $display("FAIL contention_model cyc%0d got %b exp %b", cyc, {grant, busy, owner_id, timeout_evt}, exp_vec());
         end
         if (grant != '0) begin
            if (held == 0) begin
               seq.push_back(grant);
               if (seq.size() > 1) gaps.push_back(gap);
            end
            held++;
            gap = 0;
            if (held == 3) begin
               req  = req & ~grant;
               held = 0;
            end
         end else begin
            gap++;
            req = 4'b1111;
         end
      end
      checks++;
      if (seq.size() != 5) begin
         errors++;
         $display("FAIL contention_count got %0d grants exp 5", seq.size());
      end
      for (int i = 0; i < seq.size(); i++) begin
         checks++;
         if (seq[i] !== exp_seq[i]) begin
            errors++;
            $display("FAIL contention_order idx%0d got %b exp %b", i, seq[i], exp_seq[i]);
         end
      end
      for (int i = 0; i < gaps.size(); i++) begin
         checks++;
         if (gaps[i] != 2) begin
            errors++;
            $display("FAIL contention_gap idx%0d got %0d exp 2", i, gaps[i]);
         end
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_fairness();
      do_reset();
      req = 4'b0100;
      tick();
      req = 4'b0111;
      tick();
      tick();
      req = 4'b0011;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({grant, busy, owner_id, timeout_evt} !== exp_vec()) begin
            errors++;
            $display("FAIL fairness_model cyc%0d got %b exp %b", c, {grant, busy, owner_id, timeout_evt}, exp_vec());
         end
      end
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("FAIL fairness_wrap got %b exp 0001", grant);
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_timeout();
      logic [N-1:0] exp_g[7];
      logic         exp_e[7];
      if (TO_EN) begin
         exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b1000};
         exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      end else begin
         exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
         exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      end
      do_reset();
      req = 4'b1010;
      for (int c = 0; c < 7; c++) begin
         tick();
         checks++;
         if (grant !== exp_g[c] || timeout_evt !== exp_e[c] ||
             {grant, busy, owner_id, timeout_evt} !== exp_vec()) begin
            errors++;
            $display("FAIL timeout_seq cyc%0d got g=%b e=%b exp g=%b e=%b", c, grant, timeout_evt, exp_g[c], exp_e[c]);
         end
      end
      do_reset();
      req = 4'b0010;
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++;
         if (grant !== 4'b0010 || timeout_evt !== 1'b0) begin
            errors++;
            $display("FAIL timeout_alone cyc%0d got g=%b e=%b exp g=0010 e=0", c, grant, timeout_evt);
         end
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0100;
      tick();
      tick();
      checks++;
      if (grant !== 4'b0100) begin
         errors++;
         $display("FAIL reset_mid_setup got %b exp 0100", grant);
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0 || owner_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid_async got g=%b b=%b o=%0d exp g=0000 b=0 o=0", grant, busy, owner_id);
      end
      req = 4'b0110;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (grant !== 4'b0010 || {grant, busy, owner_id, timeout_evt} !== exp_vec()) begin
         errors++;
         $display("FAIL reset_mid_regrant got %b exp 0010", grant);
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         req = req ^ N'($urandom & $urandom);
         tick();
         checks++;
         if ({grant, busy, owner_id, timeout_evt} !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc%0d req=%b got %b exp %b", c, req, {grant, busy, owner_id, timeout_evt}, exp_vec());
         end
      end
      req = '0;
   endtask

   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
      req   = '0;
      model_reset();
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
